// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / DMA) arbiter in front of a single memory with a
// fixed access latency of MEM_LAT cycles. Each transaction runs
// IDLE -> ACCESS (MEM_LAT cycles) -> ACK (one cycle) -> IDLE.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate simultaneous
// grants between the ports; otherwise the CPU has fixed priority.
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       we_r;
  logic       owner_dma;
  logic       any_req;
  logic       win_dma;

  assign any_req = cpu_req | dma_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_dma;

  // On a tie, grant the port that did not win last time.
  assign win_dma = dma_req & (~cpu_req | ~last_dma);

  // Last-grant pointer; reset to DMA so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dma <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_dma <= win_dma;
    end
  end
`else
  // Fixed priority: the DMA only wins when the CPU is not requesting.
  assign win_dma = dma_req & ~cpu_req;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe/ack decode.
  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_read  = ~we_r;
        mem_write = we_r;
        if (cnt == 4'd0) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        cpu_ack   = ~owner_dma;
        dma_ack   = owner_dma;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request capture, latency counter and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      we_r      <= 1'b0;
      owner_dma <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_dma <= win_dma;
            we_r      <= win_dma ? dma_we    : cpu_we;
            mem_addr  <= win_dma ? dma_addr  : cpu_addr;
            mem_wdata <= win_dma ? dma_wdata : cpu_wdata;
            cnt       <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!we_r) begin
              if (owner_dma) begin
                dma_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level reference (winner rule, fixed latency, per-port rdata).
module tb_mem_arbiter;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned MEM_LAT = 2;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
  logic          cpu_ack, dma_ack, mem_read, mem_write;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          rd_ovr_en;
  logic [DW-1:0] rd_ovr;

  int errors = 0;
  int checks = 0;

  // Reference state: who won last, and what each port's rdata should hold.
  bit            last_dma;
  logic [DW-1:0] exp_cpu_rd, exp_dma_rd;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory model: read data is a fixed hash of the address unless overridden.
  assign mem_rdata = rd_ovr_en ? rd_ovr : memval(mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Mutual exclusion of acks and of strobes, every cycle.
  always @(negedge clk) begin
    check("mutex", {30'b0, cpu_ack & dma_ack, mem_read & mem_write}, 32'd0);
  end

  // Winner rule: a lone requester wins; on a tie the CPU wins unless
  // round-robin is enabled, in which case the port not granted last wins.
  function automatic bit pick_dma(input bit c, input bit d);
    if (c && d) return RR ? !last_dma : 1'b0;
    return d;
  endfunction

  // One full grant, entered at a negedge with requests already driven and
  // the DUT idle; returns at the negedge of the idle cycle after the ack.
  task automatic run_grant(input bit wdma, input bit keep, input bit drop_mid);
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, v;
    we = wdma ? dma_we    : cpu_we;
    a  = wdma ? dma_addr  : cpu_addr;
    d  = wdma ? dma_wdata : cpu_wdata;
    last_dma = wdma;
    @(posedge clk);
    for (int k = 1; k <= int'(MEM_LAT); k++) begin
      @(negedge clk);
      check("mem_read",  32'(mem_read),  32'(!we));
      check("mem_write", 32'(mem_write), 32'(we));
      check("mem_addr",  mem_addr,  a);
      check("mem_wdata", mem_wdata, d);
      check("early_ack", {30'b0, cpu_ack, dma_ack}, 32'd0);
      if (drop_mid && k == 1) begin
        if (wdma) dma_req = 1'b0; else cpu_req = 1'b0;
      end
    end
    @(negedge clk);
    if (!we) begin
      v = rd_ovr_en ? rd_ovr : memval(a);
      if (wdma) exp_dma_rd = v; else exp_cpu_rd = v;
    end
    check("cpu_ack",   32'(cpu_ack), 32'(!wdma));
    check("dma_ack",   32'(dma_ack), 32'(wdma));
    check("ack_strb",  {30'b0, mem_read, mem_write}, 32'd0);
    check("cpu_rdata", cpu_rdata, exp_cpu_rd);
    check("dma_rdata", dma_rdata, exp_dma_rd);
    if (!keep) begin
      if (wdma) dma_req = 1'b0; else cpu_req = 1'b0;
    end
    @(negedge clk);
    check("idle_sig",  {28'b0, cpu_ack, dma_ack, mem_read, mem_write}, 32'd0);
    check("hold_addr", mem_addr,  a);
    check("hold_wdat", mem_wdata, d);
  endtask

  // Serve every pending request, dropping each winner's req after its ack.
  task automatic serve_all();
    bit w;
    while (cpu_req || dma_req) begin
      w = pick_dma(cpu_req, dma_req);
      run_grant(w, 1'b0, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    rd_ovr_en = 1'b0; rd_ovr = '0;
    last_dma = 1'b1; exp_cpu_rd = '0; exp_dma_rd = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl",   {28'b0, cpu_ack, dma_ack, mem_read, mem_write}, 32'd0);
    check("rst_rdata", cpu_rdata | dma_rdata, 32'd0);
    check("rst_mem",   mem_addr | mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // CPU read of 0x10 returning DEADBEEF.
    rd_ovr_en = 1'b1; rd_ovr = 32'hDEADBEEF;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    run_grant(1'b0, 1'b0, 1'b0);
    rd_ovr_en = 1'b0;

    // DMA write 0x12345678 to 0x20.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h12345678;
    run_grant(1'b1, 1'b0, 1'b0);

    // Both requests held through eight grants.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200;
    for (int i = 0; i < 8; i++) begin
      run_grant(RR ? bit'(i % 2) : 1'b0, 1'b1, 1'b0);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);

    // CPU req dropped during the access still completes with one ack.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
    run_grant(1'b0, 1'b0, 1'b1);

    // Reset during the first ACCESS cycle aborts the access.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h88;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_rd", 32'(mem_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ctl", {28'b0, cpu_ack, dma_ack, mem_read, mem_write}, 32'd0);
    check("abort_mem", mem_addr, 32'd0);
    check("abort_rd",  cpu_rdata, 32'd0);
    rst = 1'b0; cpu_req = 1'b0;
    last_dma = 1'b1; exp_cpu_rd = '0; exp_dma_rd = '0;
    repeat (4) begin
      @(negedge clk);
      check("no_ack", {28'b0, cpu_ack, dma_ack, mem_read, mem_write}, 32'd0);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    run_grant(1'b0, 1'b0, 1'b0);

    // Randomized sessions: one or both ports, mixed reads and writes.
    for (int s = 0; s < 40; s++) begin
      cpu_req = 1'($urandom_range(0, 1));
      dma_req = 1'($urandom_range(0, 1));
      if (!cpu_req && !dma_req) cpu_req = 1'b1;
      cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom; cpu_wdata = $urandom;
      dma_we = 1'($urandom_range(0, 1)); dma_addr = $urandom; dma_wdata = $urandom;
      serve_all();
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
